tile_ocl_responder: RTL and testbench

Per-tile responder for the OCL register bus. It is the slave end of the single-beat AXI-lite-style channel that the shell-side arbiter drives into each tile. It accepts one AW/W or AR transaction at a time, serves a small local register set, and forwards all other accesses to tile components over a simple pulse bus. It returns exactly one B or R response per request and never returns an error response code.

---
 rtl/tile_ocl_responder_if.sv | 39 +++
 rtl/tile_ocl_responder.sv | 154 +++++++++++++++
 tb/tb_tile_ocl_responder.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tile_ocl_responder_if.sv
// OCL single-beat register bus plus the tile-side forwarding pulse bus.
// slave: the tile responder; master: the shell-side arbiter and tile components.
interface tile_ocl_responder_if;
  logic        ocl_awvalid;
  logic        ocl_awready;
  logic [31:0] ocl_awaddr;
  logic        ocl_wvalid;
  logic        ocl_wready;
  logic [31:0] ocl_wdata;
  logic        ocl_bvalid;
  logic        ocl_bready;
  logic        ocl_arvalid;
  logic        ocl_arready;
  logic [31:0] ocl_araddr;
  logic        ocl_rvalid;
  logic [31:0] ocl_rdata;
  logic        ocl_rready;
  logic        reg_wvalid;
  logic [15:0] reg_waddr;
  logic [31:0] reg_wdata;
  logic        reg_arvalid;
  logic [15:0] reg_araddr;
  logic        reg_rvalid;
  logic [31:0] reg_rdata;

  modport slave (
    input  ocl_awvalid, ocl_awaddr, ocl_wvalid, ocl_wdata, ocl_bready,
    input  ocl_arvalid, ocl_araddr, ocl_rready, reg_rvalid, reg_rdata,
    output ocl_awready, ocl_wready, ocl_bvalid, ocl_arready, ocl_rvalid, ocl_rdata,
    output reg_wvalid, reg_waddr, reg_wdata, reg_arvalid, reg_araddr
  );

  modport master (
    output ocl_awvalid, ocl_awaddr, ocl_wvalid, ocl_wdata, ocl_bready,
    output ocl_arvalid, ocl_araddr, ocl_rready, reg_rvalid, reg_rdata,
    input  ocl_awready, ocl_wready, ocl_bvalid, ocl_arready, ocl_rvalid, ocl_rdata,
    input  reg_wvalid, reg_waddr, reg_wdata, reg_arvalid, reg_araddr
  );
endinterface

// File: rtl/tile_ocl_responder.sv
// Per-tile OCL responder: local TILE_ID/SCRATCH/WRITE_COUNT/TIMEOUT_COUNT, everything else forwarded.
// Define OCL_RESP_TIMEOUT_EN to enable the forwarded-read timeout and TIMEOUT_COUNT.
module tile_ocl_responder #(
  parameter logic [31:0] TILE_ID        = '0,
  parameter logic [7:0]  LOCAL_ID       = 8'hF0,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rstn,
  tile_ocl_responder_if.slave bus
);

  typedef enum logic [2:0] {IDLE, W_WAIT, W_FWD, B_RESP, R_FWD, R_RESP} state_t;

  state_t      r_state, w_next;
  logic [15:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic [31:0] r_scratch;
  logic [31:0] r_wcount;
  logic        r_arpulse;

  logic        w_awready, w_arready, w_wready;
  logic        w_aw_hs, w_ar_hs, w_w_hs;
  logic        w_ar_local, w_w_local;
  logic        w_timeout;
  logic [31:0] w_tocount;
  logic [31:0] w_local_rdata;
  logic        w_unused_addr;

  assign w_unused_addr = ^{bus.ocl_awaddr[31:16], bus.ocl_araddr[31:16]};

  // Ready/valid outputs are held low while rstn is asserted, not just after it.
  assign w_awready = rstn && (r_state == IDLE);
  assign w_arready = rstn && (r_state == IDLE) && !bus.ocl_awvalid;
  assign w_wready  = rstn && (r_state == W_WAIT);

  assign w_aw_hs = w_awready && bus.ocl_awvalid;
  assign w_ar_hs = w_arready && bus.ocl_arvalid;
  assign w_w_hs  = w_wready && bus.ocl_wvalid;

  assign w_ar_local = (bus.ocl_araddr[15:8] == LOCAL_ID);
  assign w_w_local  = (r_addr[15:8] == LOCAL_ID);

  assign bus.ocl_awready = w_awready;
  assign bus.ocl_arready = w_arready;
  assign bus.ocl_wready  = w_wready;
  assign bus.ocl_bvalid  = rstn && (r_state == B_RESP);
  assign bus.ocl_rvalid  = rstn && (r_state == R_RESP);
  assign bus.ocl_rdata   = r_rdata;
  assign bus.reg_wvalid  = rstn && (r_state == W_FWD);
  assign bus.reg_waddr   = r_addr;
  assign bus.reg_wdata   = r_wdata;
  assign bus.reg_arvalid = r_arpulse;
  assign bus.reg_araddr  = r_addr;

`ifdef OCL_RESP_TIMEOUT_EN
  logic [15:0] r_tcnt;
  logic [31:0] r_tocnt;

  assign w_timeout = (r_state == R_FWD) && !bus.reg_rvalid &&
                     (r_tcnt == 16'(TIMEOUT_CYCLES - 1));
  assign w_tocount = r_tocnt;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_tcnt  <= '0;
      r_tocnt <= '0;
    end else begin
      if (w_ar_hs)
        r_tcnt <= '0;
      else if (r_state == R_FWD)
        r_tcnt <= r_tcnt + 16'd1;
      if (w_timeout && (r_tocnt != '1))
        r_tocnt <= r_tocnt + 32'd1;
    end
  end
`else
  assign w_timeout = 1'b0;
  assign w_tocount = '0;
`endif

  always_comb begin
    w_local_rdata = '0;
    case (bus.ocl_araddr[7:0])
      8'h00:   w_local_rdata = TILE_ID;
      8'h04:   w_local_rdata = r_scratch;
      8'h08:   w_local_rdata = r_wcount;
      8'h0C:   w_local_rdata = w_tocount;
      default: w_local_rdata = '0;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_aw_hs)
          w_next = W_WAIT;
        else if (w_ar_hs)
          w_next = w_ar_local ? R_RESP : R_FWD;
      end
      W_WAIT: if (w_w_hs) w_next = w_w_local ? B_RESP : W_FWD;
      W_FWD:  w_next = B_RESP;
      B_RESP: if (bus.ocl_bready) w_next = IDLE;
      R_FWD:  if (bus.reg_rvalid || w_timeout) w_next = R_RESP;
      R_RESP: if (bus.ocl_rready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state   <= IDLE;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_scratch <= '0;
      r_wcount  <= '0;
      r_arpulse <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_arpulse <= 1'b0;
      if (w_aw_hs)
        r_addr <= bus.ocl_awaddr[15:0];
      if (w_ar_hs) begin
        r_addr <= bus.ocl_araddr[15:0];
        if (w_ar_local)
          r_rdata <= w_local_rdata;
        else
          r_arpulse <= 1'b1;
      end
      // Local writes count at the W handshake, forwarded ones in W_FWD.
      if (w_w_hs) begin
        if (w_w_local) begin
          if (r_addr[7:0] == 8'h04)
            r_scratch <= bus.ocl_wdata;
          r_wcount <= r_wcount + 32'd1;
        end else begin
          r_wdata <= bus.ocl_wdata;
        end
      end
      if (r_state == W_FWD)
        r_wcount <= r_wcount + 32'd1;
      if (r_state == R_FWD) begin
        if (bus.reg_rvalid)
          r_rdata <= bus.reg_rdata;
        else if (w_timeout)
          r_rdata <= 32'hDEADBEEF;
      end
    end
  end

endmodule

// File: tb/tb_tile_ocl_responder.sv
// Directed self-checking bench for tile_ocl_responder.
module tb_tile_ocl_responder;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tile_ocl_responder_if bus();

  tile_ocl_responder #(
    .TILE_ID(32'h0000_0007),
    .LOCAL_ID(8'hF0),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .bus(bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, output logic ok);
    int n;
    ok = 1'b1;
    bus.ocl_awvalid = 1'b1;
    bus.ocl_awaddr  = addr;
    n = 0;
    while (!bus.ocl_awready && n < 50) begin tick(); n++; end
    if (!bus.ocl_awready) ok = 1'b0;
    tick();
    bus.ocl_awvalid = 1'b0;
    bus.ocl_wvalid  = 1'b1;
    bus.ocl_wdata   = data;
    n = 0;
    while (!bus.ocl_wready && n < 50) begin tick(); n++; end
    if (!bus.ocl_wready) ok = 1'b0;
    tick();
    bus.ocl_wvalid = 1'b0;
    n = 0;
    while (!bus.ocl_bvalid && n < 50) begin tick(); n++; end
    if (!bus.ocl_bvalid) ok = 1'b0;
    bus.ocl_bready = 1'b1;
    tick();
    bus.ocl_bready = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] addr, output logic [31:0] data, output logic ok);
    int n;
    ok = 1'b1;
    bus.ocl_arvalid = 1'b1;
    bus.ocl_araddr  = addr;
    n = 0;
    while (!bus.ocl_arready && n < 50) begin tick(); n++; end
    if (!bus.ocl_arready) ok = 1'b0;
    tick();
    bus.ocl_arvalid = 1'b0;
    n = 0;
    while (!bus.ocl_rvalid && n < 50) begin tick(); n++; end
    if (!bus.ocl_rvalid) ok = 1'b0;
    data = bus.ocl_rdata;
    bus.ocl_rready = 1'b1;
    tick();
    bus.ocl_rready = 1'b0;
  endtask

  task automatic test_reset();
    logic [128:0] outs;
    rstn = 1'b0;
    repeat (3) tick();
    outs = {bus.ocl_awready, bus.ocl_arready, bus.ocl_wready, bus.ocl_bvalid, bus.ocl_rvalid,
            bus.reg_wvalid, bus.reg_arvalid, bus.ocl_rdata, bus.reg_waddr, bus.reg_wdata, bus.reg_araddr};
    checks++;
    if (outs !== '0) begin errors++; $display("FAIL reset_outputs got %h want 0", outs); end
    rstn = 1'b1;
    tick();
    checks++;
    if (bus.ocl_awready !== 1'b1) begin errors++; $display("FAIL idle_awready got %b want 1", bus.ocl_awready); end
  endtask

  task automatic test_local_write();
    logic [31:0] d;
    logic ok;
    bus.ocl_awvalid = 1'b1;
    bus.ocl_awaddr  = 32'h0000_F004;
    tick();
    bus.ocl_awvalid = 1'b0;
    bus.ocl_wvalid  = 1'b1;
    bus.ocl_wdata   = 32'hA5A5_0001;
    checks++;
    if (bus.ocl_wready !== 1'b1) begin errors++; $display("FAIL lw_wready got %b want 1", bus.ocl_wready); end
    tick();
    bus.ocl_wvalid = 1'b0;
    checks++;
    if (bus.ocl_bvalid !== 1'b1) begin errors++; $display("FAIL lw_bvalid_t1 got %b want 1", bus.ocl_bvalid); end
    bus.ocl_bready = 1'b1;
    tick();
    bus.ocl_bready = 1'b0;
    checks++;
    if (bus.ocl_bvalid !== 1'b0) begin errors++; $display("FAIL lw_bvalid_drop got %b want 0", bus.ocl_bvalid); end
    do_read(32'h0000_F004, d, ok);
    checks++;
    if (!ok || d !== 32'hA5A5_0001) begin errors++; $display("FAIL lw_scratch got %h ok %b want a5a50001", d, ok); end
    do_read(32'h0000_F008, d, ok);
    checks++;
    if (!ok || d !== 32'd1) begin errors++; $display("FAIL lw_wcount got %h want 1", d); end
  endtask

  task automatic test_local_regs();
    logic [31:0] d;
    logic ok;
    do_write(32'h0000_F000, 32'hFFFF_FFFF, ok);
    do_read(32'h0000_F000, d, ok);
    checks++;
    if (!ok || d !== 32'h0000_0007) begin errors++; $display("FAIL tile_id got %h want 7", d); end
    do_read(32'h0000_F008, d, ok);
    checks++;
    if (!ok || d !== 32'd2) begin errors++; $display("FAIL ro_write_counted got %h want 2", d); end
    do_read(32'h0000_F010, d, ok);
    checks++;
    if (!ok || d !== 32'd0) begin errors++; $display("FAIL unmapped_read got %h want 0", d); end
    do_read(32'h0000_F00C, d, ok);
    checks++;
    if (!ok || d !== 32'd0) begin errors++; $display("FAIL timeout_count_init got %h want 0", d); end
  endtask

  task automatic test_fwd_write();
    logic [31:0] d;
    logic ok;
    bus.ocl_awvalid = 1'b1;
    bus.ocl_awaddr  = 32'h00AB_0310;
    tick();
    bus.ocl_awvalid = 1'b0;
    bus.ocl_wvalid  = 1'b1;
    bus.ocl_wdata   = 32'h0000_1234;
    tick();
    bus.ocl_wvalid = 1'b0;
    checks++;
    if ({bus.reg_wvalid, bus.reg_waddr, bus.reg_wdata, bus.ocl_bvalid} !== {1'b1, 16'h0310, 32'h0000_1234, 1'b0}) begin
      errors++;
      $display("FAIL fw_pulse got v=%b a=%h d=%h b=%b want v=1 a=0310 d=00001234 b=0",
               bus.reg_wvalid, bus.reg_waddr, bus.reg_wdata, bus.ocl_bvalid);
    end
    tick();
    checks++;
    if ({bus.reg_wvalid, bus.ocl_bvalid} !== 2'b01) begin
      errors++; $display("FAIL fw_bvalid got wv=%b b=%b want wv=0 b=1", bus.reg_wvalid, bus.ocl_bvalid);
    end
    ok = 1'b1;
    repeat (5) begin
      tick();
      if (bus.ocl_bvalid !== 1'b1 || bus.reg_wvalid !== 1'b0) ok = 1'b0;
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL fw_bvalid_hold got dropped want held 1"); end
    bus.ocl_bready = 1'b1;
    tick();
    bus.ocl_bready = 1'b0;
    checks++;
    if (bus.ocl_bvalid !== 1'b0) begin errors++; $display("FAIL fw_bvalid_drop got %b want 0", bus.ocl_bvalid); end
    do_read(32'h0000_F008, d, ok);
    checks++;
    if (!ok || d !== 32'd3) begin errors++; $display("FAIL fw_wcount got %h want 3", d); end
  endtask

  task automatic test_fwd_read();
    logic ok;
    bus.ocl_arvalid = 1'b1;
    bus.ocl_araddr  = 32'h0000_0204;
    tick();
    bus.ocl_arvalid = 1'b0;
    checks++;
    if (bus.reg_arvalid !== 1'b1 || bus.reg_araddr !== 16'h0204) begin
      errors++; $display("FAIL fr_pulse got v=%b a=%h want v=1 a=0204", bus.reg_arvalid, bus.reg_araddr);
    end
    ok = 1'b1;
    repeat (6) begin
      tick();
      if (bus.reg_arvalid !== 1'b0 || bus.ocl_rvalid !== 1'b0) ok = 1'b0;
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL fr_wait got early rvalid or repeated arvalid want quiet"); end
    bus.reg_rvalid = 1'b1;
    bus.reg_rdata  = 32'h0000_CAFE;
    tick();
    bus.reg_rvalid = 1'b0;
    checks++;
    if (bus.ocl_rvalid !== 1'b1 || bus.ocl_rdata !== 32'h0000_CAFE) begin
      errors++; $display("FAIL fr_rdata got v=%b d=%h want v=1 d=0000cafe", bus.ocl_rvalid, bus.ocl_rdata);
    end
    bus.ocl_rready = 1'b1;
    tick();
    bus.ocl_rready = 1'b0;
    bus.reg_rvalid = 1'b1;
    bus.reg_rdata  = 32'h0000_0BAD;
    tick();
    bus.reg_rvalid = 1'b0;
    tick();
    checks++;
    if ({bus.ocl_rvalid, bus.ocl_awready, bus.ocl_rdata} !== {1'b0, 1'b1, 32'h0000_CAFE}) begin
      errors++; $display("FAIL stray_rvalid got v=%b awr=%b d=%h want v=0 awr=1 d=0000cafe",
                         bus.ocl_rvalid, bus.ocl_awready, bus.ocl_rdata);
    end
  endtask

  task automatic test_collision();
    bus.ocl_awvalid = 1'b1;
    bus.ocl_awaddr  = 32'h0000_F004;
    bus.ocl_arvalid = 1'b1;
    bus.ocl_araddr  = 32'h0000_F004;
    #1;
    checks++;
    if ({bus.ocl_awready, bus.ocl_arready} !== 2'b10) begin
      errors++; $display("FAIL col_ready got aw=%b ar=%b want aw=1 ar=0", bus.ocl_awready, bus.ocl_arready);
    end
    tick();
    bus.ocl_awvalid = 1'b0;
    bus.ocl_wvalid  = 1'b1;
    bus.ocl_wdata   = 32'h5555_AAAA;
    tick();
    bus.ocl_wvalid = 1'b0;
    checks++;
    if ({bus.ocl_bvalid, bus.ocl_arready} !== 2'b10) begin
      errors++; $display("FAIL col_b got b=%b ar=%b want b=1 ar=0", bus.ocl_bvalid, bus.ocl_arready);
    end
    bus.ocl_bready = 1'b1;
    tick();
    bus.ocl_bready = 1'b0;
    checks++;
    if (bus.ocl_arready !== 1'b1) begin errors++; $display("FAIL col_ar_after_b got %b want 1", bus.ocl_arready); end
    tick();
    bus.ocl_arvalid = 1'b0;
    checks++;
    if (bus.ocl_rvalid !== 1'b1 || bus.ocl_rdata !== 32'h5555_AAAA) begin
      errors++; $display("FAIL col_read got v=%b d=%h want v=1 d=5555aaaa", bus.ocl_rvalid, bus.ocl_rdata);
    end
    bus.ocl_rready = 1'b1;
    tick();
    bus.ocl_rready = 1'b0;
  endtask

  task automatic test_timeout();
    int n;
`ifdef OCL_RESP_TIMEOUT_EN
    logic [31:0] d;
    logic ok;
`endif
    bus.ocl_arvalid = 1'b1;
    bus.ocl_araddr  = 32'h0000_0500;
    tick();
    bus.ocl_arvalid = 1'b0;
`ifdef OCL_RESP_TIMEOUT_EN
    n = 0;
    while (!bus.ocl_rvalid && n < 100) begin tick(); n++; end
    checks++;
    if (n != 16 || bus.ocl_rdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL timeout got cycles=%0d d=%h want cycles=16 d=deadbeef", n, bus.ocl_rdata);
    end
    bus.ocl_rready = 1'b1;
    tick();
    bus.ocl_rready = 1'b0;
    do_read(32'h0000_F00C, d, ok);
    checks++;
    if (!ok || d !== 32'd1) begin errors++; $display("FAIL timeout_count got %h want 1", d); end
`else
    n = 0;
    repeat (1000) begin
      tick();
      if (bus.ocl_rvalid) n++;
    end
    checks++;
    if (n != 0) begin errors++; $display("FAIL no_timeout got %0d rvalid cycles want 0", n); end
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    tick();
`endif
  endtask

  task automatic test_reset_midflight();
    logic [128:0] outs;
    logic [31:0] d;
    logic ok;
    bus.ocl_arvalid = 1'b1;
    bus.ocl_araddr  = 32'h0000_0600;
    tick();
    bus.ocl_arvalid = 1'b0;
    tick();
    tick();
    rstn = 1'b0;
    tick();
    outs = {bus.ocl_awready, bus.ocl_arready, bus.ocl_wready, bus.ocl_bvalid, bus.ocl_rvalid,
            bus.reg_wvalid, bus.reg_arvalid, bus.ocl_rdata, bus.reg_waddr, bus.reg_wdata, bus.reg_araddr};
    checks++;
    if (outs !== '0) begin errors++; $display("FAIL midreset_outputs got %h want 0", outs); end
    rstn = 1'b1;
    tick();
    bus.reg_rvalid = 1'b1;
    bus.reg_rdata  = 32'h0000_0077;
    tick();
    bus.reg_rvalid = 1'b0;
    tick();
    checks++;
    if ({bus.ocl_rvalid, bus.ocl_awready, bus.ocl_rdata} !== {1'b0, 1'b1, 32'h0}) begin
      errors++; $display("FAIL late_rvalid got v=%b awr=%b d=%h want v=0 awr=1 d=0",
                         bus.ocl_rvalid, bus.ocl_awready, bus.ocl_rdata);
    end
    do_read(32'h0000_F004, d, ok);
    checks++;
    if (!ok || d !== 32'd0) begin errors++; $display("FAIL scratch_after_reset got %h want 0", d); end
    do_read(32'h0000_F008, d, ok);
    checks++;
    if (!ok || d !== 32'd0) begin errors++; $display("FAIL wcount_after_reset got %h want 0", d); end
  endtask

  initial begin
    bus.ocl_awvalid = 1'b0;
    bus.ocl_awaddr  = '0;
    bus.ocl_wvalid  = 1'b0;
    bus.ocl_wdata   = '0;
    bus.ocl_bready  = 1'b0;
    bus.ocl_arvalid = 1'b0;
    bus.ocl_araddr  = '0;
    bus.ocl_rready  = 1'b0;
    bus.reg_rvalid  = 1'b0;
    bus.reg_rdata   = '0;
    test_reset();
    test_local_write();
    test_local_regs();
    test_fwd_write();
    test_fwd_read();
    test_collision();
    test_timeout();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
